// File: rtl/fp_normalizer.sv
// Post-add normalise/pack stage for binary32: carry right-shift, iterative
// left-shift to the hidden bit, then pack with zero/overflow flags.
module fp_normalizer #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W-1:0]         in_mant,
  input  logic                      in_carry,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  output logic                      out_valid,
  output logic [EXP_W+MANT_W-1:0]   out_result,
  output logic                      out_zero,
  output logic                      out_overflow
);

  localparam int FRAC_W = MANT_W - 1;
  localparam int RES_W  = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [RES_W-1:0]    res_q, res_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                vld_q, vld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          state_d = SHIFT;
          if (in_carry) begin
            mant_d = {1'b1, in_mant[MANT_W-1:1]};
            // Saturate so an all-ones exponent still reports overflow
            exp_d  = (in_exp == EXP_ONES) ? EXP_ONES
                                          : in_exp + EXP_ONE;
          end else begin
            mant_d = in_mant;
            exp_d  = in_exp;
          end
        end
      end
      SHIFT: begin
        if (mant_q == '0) begin
          res_d   = '0;
          zero_d  = 1'b1;
          ovf_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else if (exp_q == EXP_ONES) begin
          res_d   = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
          zero_d  = 1'b0;
          ovf_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else if (mant_q[MANT_W-1]) begin
          res_d   = {sign_q, exp_q, mant_q[FRAC_W-1:0]};
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else if (exp_q <= EXP_ONE) begin
          res_d   = {sign_q, {EXP_W{1'b0}}, mant_q[FRAC_W-1:0]};
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = vld_q;
  assign out_result   = res_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed vectors push expectations,
// a negedge monitor pops and checks result, flags and latency.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic        in_carry;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;

  fp_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mant      (in_mant),
    .in_carry     (in_carry),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   accepts;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got result %h", out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", out_result, e.res);
        chk("zero", 32'(out_zero), 32'(e.z));
        chk("overflow", 32'(out_overflow), 32'(e.o));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Called at a negedge; holds in_valid for 'hold' cycles
  task automatic drive(input logic [23:0] m, input logic c,
                       input logic s, input logic [7:0] ex,
                       input int hold, input logic [31:0] r,
                       input logic z, input logic o, input int k,
                       input bit push);
    exp_t e;
    in_mant  = m;
    in_carry = c;
    in_sign  = s;
    in_exp   = ex;
    in_valid = 1'b1;
    accepts  = 0;
    for (int h = 0; h < hold; h++) begin
      if (in_ready) begin
        accepts++;
        if (push) begin
          e.res = r;
          e.z   = z;
          e.o   = o;
          e.lat = k + 2;
          e.acc = cyc;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid_timeout: got 0 expected 1");
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_mant  = '0;
    in_carry = 1'b0;
    in_sign  = 1'b0;
    in_exp   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", {30'd0, out_zero, out_overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    drive(24'hC00000, 0, 0, 8'd127, 1, 32'h3FC00000, 0, 0, 0, 1);
    drain();
    drive(24'h000000, 1, 0, 8'd127, 1, 32'h40000000, 0, 0, 0, 1);
    drain();
    drive(24'h000001, 0, 1, 8'd127, 1, 32'hB4000000, 0, 0, 23, 1);
    drain();
    drive(24'h000000, 0, 1, 8'd127, 1, 32'h00000000, 1, 0, 0, 1);
    drain();
    drive(24'h00F000, 0, 0, 8'd130, 1, 32'h3D700000, 0, 0, 8, 1);
    drain();
    drive(24'h000000, 1, 0, 8'd254, 1, 32'h7F800000, 0, 1, 0, 1);
    drain();
    drive(24'h000100, 0, 0, 8'd3, 1, 32'h00000400, 0, 0, 2, 1);
    drain();
    drive(24'h400000, 0, 0, 8'd0, 1, 32'h00400000, 0, 0, 0, 1);
    drain();

    // Held level: accepted, ignored while busy, retriggered on out_valid
    drive(24'hC00000, 0, 0, 8'd127, 3, 32'h3FC00000, 0, 0, 0, 1);
    chk("held_accepts", 32'(accepts), 32'd2);
    drain();

    // Back-to-back: second pulse lands in the out_valid cycle
    drive(24'h000100, 0, 0, 8'd3, 1, 32'h00000400, 0, 0, 2, 1);
    wait_valid();
    chk("b2b_ready", 32'(in_ready), 32'd1);
    drive(24'h000000, 1, 1, 8'd127, 1, 32'hC0000000, 0, 0, 0, 1);
    drain();

    // Abort a long op with reset at edge 10
    drive(24'h000001, 0, 1, 8'd127, 1, 32'h0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_result", out_result, 32'h0);
    chk("abort_flags", {30'd0, out_zero, out_overflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
